// File: rtl/dac_scan_seq.sv
// DAC code scan sequencer: steps a one-hot DAC channel from code_start to code_stop,
// writing each code, waiting for settling, then handing the step to an external counter.
module dac_scan_seq #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned SETTLE_US = 10
) (
  input  logic        clk,
  input  logic        nRES,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  ch_mask,
  input  logic [11:0] code_start,
  input  logic [11:0] code_stop,
  input  logic [11:0] code_step,
  input  logic        gate_done,
  output logic        we32,
  output logic [7:0]  addr,
  output logic [31:0] data_in32,
  output logic        startStep,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [11:0] cur_code,
  output logic [12:0] step_idx
);

  localparam int unsigned SETTLE_CYC = (CLK_FREQ / 1000000) * SETTLE_US;
  localparam int unsigned CNT_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned CODE_W     = 12;
  localparam int unsigned IDX_W      = 13;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [7:0]       REG_ADDR = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_SETTLE,
    S_COUNT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_n;

  logic               r_run;
  logic [3:0]         r_mask;
  logic [CODE_W-1:0]  r_first;
  logic [CODE_W-1:0]  r_stop;
  logic [CODE_W-1:0]  r_step;
  logic [CNT_W-1:0]   r_cnt;
  logic [CODE_W-1:0]  r_cur;
  logic [IDX_W-1:0]   r_idx;
  logic               r_we32;
  logic [7:0]         r_addr;
  logic [31:0]        r_data;
  logic               r_start_step;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic [3:0]         w_mask_n;
  logic [CODE_W-1:0]  w_first_n;
  logic [CODE_W-1:0]  w_stop_n;
  logic [CODE_W-1:0]  w_step_n;
  logic [CNT_W-1:0]   w_cnt_n;
  logic [CODE_W-1:0]  w_code_n;
  logic [IDX_W-1:0]   w_idx_n;
  logic               w_we_n;
  logic [7:0]         w_addr_n;
  logic [31:0]        w_data_n;
  logic               w_ss_n;
  logic               w_busy_n;
  logic               w_done_n;
  logic               w_err_n;

  logic               w_onehot;
  logic               w_cfg_ok;
  logic [CODE_W:0]    w_sum;
  logic               w_over;

  assign w_onehot = (ch_mask == 4'b1000) || (ch_mask == 4'b0100) ||
                    (ch_mask == 4'b0010) || (ch_mask == 4'b0001);
  assign w_cfg_ok = (code_step != '0) && (code_start <= code_stop) && w_onehot;

  // Sum kept one bit wider so a carry out of 4095 ends the scan instead of wrapping.
  assign w_sum  = {1'b0, r_cur} + {1'b0, r_step};
  assign w_over = w_sum[CODE_W] || (w_sum[CODE_W-1:0] > r_stop);

  // Reset release is retimed: the FSM ignores start until one edge after nRES rises.
  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_first      <= '0;
      r_stop       <= '0;
      r_step       <= '0;
      r_cnt        <= '0;
      r_cur        <= '0;
      r_idx        <= '0;
      r_we32       <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_start_step <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_mask       <= w_mask_n;
      r_first      <= w_first_n;
      r_stop       <= w_stop_n;
      r_step       <= w_step_n;
      r_cnt        <= w_cnt_n;
      r_cur        <= w_code_n;
      r_idx        <= w_idx_n;
      r_we32       <= w_we_n;
      r_addr       <= w_addr_n;
      r_data       <= w_data_n;
      r_start_step <= w_ss_n;
      r_busy       <= w_busy_n;
      r_done       <= w_done_n;
      r_err        <= w_err_n;
    end
  end

  // Next-state and next-output logic; outputs are decided one cycle ahead and registered.
  always_comb begin
    w_state_n = r_state;
    w_mask_n  = r_mask;
    w_first_n = r_first;
    w_stop_n  = r_stop;
    w_step_n  = r_step;
    w_cnt_n   = r_cnt;
    w_code_n  = r_cur;
    w_idx_n   = r_idx;
    w_we_n    = 1'b0;
    w_ss_n    = 1'b0;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start && r_run && !abort) begin
          if (w_cfg_ok) begin
            w_state_n = S_LOAD;
            w_mask_n  = ch_mask;
            w_first_n = code_start;
            w_stop_n  = code_stop;
            w_step_n  = code_step;
          end else begin
            w_err_n = 1'b1;
          end
        end
      end
      S_LOAD: begin
        w_code_n  = r_first;
        w_idx_n   = '0;
        w_cnt_n   = CNT_LOAD;
        w_we_n    = 1'b1;
        w_state_n = S_WRITE;
      end
      // The write cycle already counts as the first settling cycle.
      S_WRITE, S_SETTLE: begin
        if (r_cnt == '0) begin
          w_ss_n    = 1'b1;
          w_state_n = S_COUNT;
        end else begin
          w_cnt_n   = r_cnt - CNT_W'(1);
          w_state_n = S_SETTLE;
        end
      end
      S_COUNT: begin
        if (gate_done) begin
          w_state_n = S_NEXT;
        end
      end
      S_NEXT: begin
        if (w_over) begin
          w_done_n  = 1'b1;
          w_state_n = S_DONE;
        end else begin
          w_code_n  = w_sum[CODE_W-1:0];
          w_idx_n   = r_idx + IDX_W'(1);
          w_cnt_n   = CNT_LOAD;
          w_we_n    = 1'b1;
          w_state_n = S_WRITE;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // Abort overrides every other event of the same cycle.
    if (abort && (r_state != S_IDLE)) begin
      w_state_n = S_IDLE;
      w_code_n  = r_cur;
      w_idx_n   = r_idx;
      w_cnt_n   = '0;
      w_we_n    = 1'b0;
      w_ss_n    = 1'b0;
      w_done_n  = 1'b0;
    end

    w_busy_n = (w_state_n != S_IDLE);
    w_addr_n = w_we_n ? REG_ADDR : 8'h00;
    w_data_n = {16'h0000, w_mask_n, w_code_n};
  end

  assign we32      = r_we32;
  assign addr      = r_addr;
  assign data_in32 = r_data;
  assign startStep = r_start_step;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign cur_code  = r_cur;
  assign step_idx  = r_idx;

endmodule
